// File: rtl/icache_if.sv
// Fetch-side and byte-serial memory-side signals of the instruction cache.
// The master modport is the cache; the slave modport is the fetch stage plus arbiter/RAM.
interface icache_if;
  logic [31:0] if_addr_in;
  logic        instr_out_en;
  logic [31:0] instr_out;
  logic        mem_req;
  logic        mem_grant;
  logic [31:0] mem_a;
  logic [7:0]  mem_din;

  modport master (
    input  if_addr_in, mem_grant, mem_din,
    output instr_out_en, instr_out, mem_req, mem_a
  );

  modport slave (
    output if_addr_in, mem_grant, mem_din,
    input  instr_out_en, instr_out, mem_req, mem_a
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache: zero-latency hit path, whole-line refill
// through a byte-serial read port, one byte requested per granted cycle.
//
// state | meaning
// IDLE  | look up if_addr_in, start a refill on a miss
// FILL  | issue the 16 byte reads of the latched line
// DRAIN | wait for the last in-flight byte, then write the line
module icache #(
  parameter int LINE_NUM   = 64,
  parameter int LINE_BYTES = 16
) (
  input  logic      clk,
  input  logic      rst_in,
  input  logic      rdy_in,
  input  logic      roll_back,
  icache_if.master  bus
);

  localparam int IDX_W  = $clog2(LINE_NUM);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam logic [OFF_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t state, state_nxt;

  logic [LINE_NUM-1:0] valid;
  logic [TAG_W-1:0]    tag_mem  [LINE_NUM];
  logic [LINE_W-1:0]   data_mem [LINE_NUM];

  logic [31-OFF_W:0]   line_base;
  logic [OFF_W-1:0]    issue_cnt;
  logic [OFF_W-1:0]    rcv_cnt;
  logic                pending;
  logic                filled;
  logic [LINE_W-1:0]   fill_buf;
  logic [LINE_W-1:0]   fill_buf_nxt;

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic                hit;
  logic [LINE_W-1:0]   line_rd;
  logic [IDX_W-1:0]    fill_idx;
  logic [TAG_W-1:0]    fill_tag;
  logic                last_byte;
  logic                issue;
  logic                start;
  logic                commit;
  logic                unused_addr_bits;

  assign idx      = bus.if_addr_in[IDX_W+OFF_W-1:OFF_W];
  assign tag      = bus.if_addr_in[31:IDX_W+OFF_W];
  assign hit      = valid[idx] && (tag_mem[idx] == tag);
  assign line_rd  = data_mem[idx];
  assign bus.instr_out = line_rd[{bus.if_addr_in[OFF_W-1:2], 5'b0} +: 32];
  assign unused_addr_bits = ^bus.if_addr_in[1:0];

  assign fill_idx  = line_base[IDX_W-1:0];
  assign fill_tag  = line_base[31-OFF_W:IDX_W];
  assign last_byte = pending && (rcv_cnt == '1);

  // Byte capture is independent of state and rdy_in: an issued read always lands.
  always_comb begin
    fill_buf_nxt = fill_buf;
    if (pending) fill_buf_nxt[{rcv_cnt, 3'b000} +: 8] = bus.mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    issue            = 1'b0;
    start            = 1'b0;
    commit           = 1'b0;
    bus.instr_out_en = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_a        = '0;
    case (state)
      IDLE: begin
        bus.instr_out_en = hit && rdy_in && !roll_back && !rst_in;
        if (!hit && rdy_in && !roll_back) begin
          start     = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        bus.mem_req = 1'b1;
        bus.mem_a   = {line_base, issue_cnt};
        if (roll_back) begin
          state_nxt = IDLE;
        end else if (rdy_in && bus.mem_grant) begin
          issue = 1'b1;
          if (issue_cnt == '1) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // filled covers a last byte that arrived while rdy_in was low
        if (roll_back) begin
          state_nxt = IDLE;
        end else if (rdy_in && (filled || last_byte)) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      valid     <= '0;
      line_base <= '0;
      issue_cnt <= '0;
      rcv_cnt   <= '0;
      pending   <= 1'b0;
      filled    <= 1'b0;
    end else begin
      pending <= issue;
      if (issue)   issue_cnt <= issue_cnt + CNT_ONE;
      if (pending) rcv_cnt   <= rcv_cnt + CNT_ONE;
      if ((state == DRAIN) && last_byte) filled <= 1'b1;
      if (start) begin
        line_base <= bus.if_addr_in[31:OFF_W];
        issue_cnt <= '0;
        rcv_cnt   <= '0;
        filled    <= 1'b0;
      end
      if (commit) begin
        valid[fill_idx] <= 1'b1;
        filled          <= 1'b0;
      end
      if (roll_back && (state != IDLE)) filled <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    fill_buf <= fill_buf_nxt;
    if (commit) begin
      data_mem[fill_idx] <= fill_buf_nxt;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized fetches
// checked against a line-presence model and per-fetch timing computed from stimulus.
module tb_icache;
  logic clk = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic roll_back;

  icache_if ifc ();

  icache dut (
    .clk       (clk),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .roll_back (roll_back),
    .bus       (ifc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  bit          model_valid [64];
  logic [27:0] model_base  [64];

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24];
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return {ram_byte(a + 32'd3), ram_byte(a + 32'd2), ram_byte(a + 32'd1), ram_byte(a)};
  endfunction

  // RAM: returns the byte of a granted request in the following cycle
  initial begin : ram_resp
    logic        issued;
    logic [31:0] ia;
    ifc.mem_din = 8'h00;
    forever begin
      @(negedge clk);
      issued = ifc.mem_req && ifc.mem_grant;
      ia     = ifc.mem_a;
      @(posedge clk);
      #1;
      ifc.mem_din = issued ? ram_byte(ia) : 8'($urandom);
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One fetch of addr with grant/rdy patterns; expected timing derived from the patterns.
  task automatic fetch(input logic [31:0] addr, input int gmode, input int rmode, output int obs_e);
    bit          g [256];
    bit          r [256];
    int          d, m, x, e, iss;
    bit          hit, en_exp, req_exp;
    logic [5:0]  idx;
    logic [31:0] base, a_exp;
    idx  = addr[9:4];
    base = {addr[31:4], 4'h0};
    for (int c = 0; c < 256; c++) begin
      case (gmode)
        0:       g[c] = 1'b1;
        1:       g[c] = (c % 2 == 1);
        default: g[c] = ($urandom_range(3) != 0);
      endcase
      case (rmode)
        0:       r[c] = 1'b1;
        1:       r[c] = !(c >= 5 && c <= 7);
        default: r[c] = ($urandom_range(7) != 0);
      endcase
      if (c >= 150) begin
        g[c] = 1'b1;
        r[c] = 1'b1;
      end
    end
    hit = model_valid[idx] && (model_base[idx] == addr[31:4]);
    d = 0;
    while (!r[d]) d++;
    if (hit) begin
      e = d;
      m = -1;
    end else begin
      iss = 0;
      m   = d;
      while (iss < 16) begin
        m++;
        if (g[m] && r[m]) iss++;
      end
      x = m + 1;
      while (!r[x]) x++;
      e = x + 1;
      while (!r[e]) e++;
    end
    obs_e = -1;
    iss   = 0;
    for (int c = 0; c <= e; c++) begin
      ifc.if_addr_in = addr;
      ifc.mem_grant  = g[c];
      rdy_in         = r[c];
      roll_back      = 1'b0;
      en_exp  = (c == e);
      req_exp = !hit && (c > d) && (c <= m);
      a_exp   = req_exp ? base + iss : 32'h0;
      @(negedge clk);
      n_cmp++;
      if (ifc.instr_out_en !== en_exp) begin
        n_err++;
        $display("FAIL fetch_en addr=%h cyc=%0d got=%b want=%b", addr, c, ifc.instr_out_en, en_exp);
      end
      if (ifc.instr_out_en === 1'b1 && obs_e < 0) obs_e = c;
      if (en_exp) begin
        n_cmp++;
        if (ifc.instr_out !== ram_word(addr)) begin
          n_err++;
          $display("FAIL fetch_instr addr=%h got=%h want=%h", addr, ifc.instr_out, ram_word(addr));
        end
      end
      n_cmp++;
      if (ifc.mem_req !== req_exp) begin
        n_err++;
        $display("FAIL fetch_req addr=%h cyc=%0d got=%b want=%b", addr, c, ifc.mem_req, req_exp);
      end
      n_cmp++;
      if (ifc.mem_a !== a_exp) begin
        n_err++;
        $display("FAIL fetch_mem_a addr=%h cyc=%0d got=%h want=%h", addr, c, ifc.mem_a, a_exp);
      end
      if (req_exp && g[c] && r[c]) iss++;
      next_cycle();
    end
    if (!hit) begin
      model_valid[idx] = 1'b1;
      model_base[idx]  = addr[31:4];
    end
  endtask

  task automatic check_latency(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s latency got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst_in         = 1'b1;
    rdy_in         = 1'b1;
    roll_back      = 1'b0;
    ifc.mem_grant  = 1'b1;
    ifc.if_addr_in = 32'h8;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c > 0) begin
        n_cmp++;
        if (ifc.instr_out_en !== 1'b0) begin
          n_err++;
          $display("FAIL reset_en cyc=%0d got=%b want=0", c, ifc.instr_out_en);
        end
        n_cmp++;
        if (ifc.mem_req !== 1'b0) begin
          n_err++;
          $display("FAIL reset_req cyc=%0d got=%b want=0", c, ifc.mem_req);
        end
        n_cmp++;
        if (ifc.mem_a !== 32'h0) begin
          n_err++;
          $display("FAIL reset_mem_a cyc=%0d got=%h want=0", c, ifc.mem_a);
        end
      end
      next_cycle();
    end
    rst_in = 1'b0;
    for (int i = 0; i < 64; i++) model_valid[i] = 1'b0;
  endtask

  task automatic test_first_fill();
    int oe;
    ifc.if_addr_in = 32'h0;
    fetch(32'h0, 0, 0, oe);
    check_latency("first_fill", oe, 18);
  endtask

  task automatic test_hit_same_line();
    int oe;
    fetch(32'h8, 0, 0, oe);
    check_latency("hit_0x8", oe, 0);
    fetch(32'h4, 0, 0, oe);
    check_latency("hit_0x4", oe, 0);
    fetch(32'hC, 0, 0, oe);
    check_latency("hit_0xc", oe, 0);
  endtask

  task automatic test_conflict();
    int oe;
    fetch(32'h400, 0, 0, oe);
    check_latency("conflict_fill", oe, 18);
    fetch(32'h404, 0, 0, oe);
    check_latency("conflict_hit", oe, 0);
    fetch(32'h0, 0, 0, oe);
    check_latency("conflict_refill", oe, 18);
  endtask

  task automatic test_grant_toggle();
    int oe;
    fetch(32'h2A0, 1, 0, oe);
    check_latency("grant_toggle", oe, 33);
    for (int w = 0; w < 4; w++) begin
      fetch(32'h2A0 + 32'(w * 4), 0, 0, oe);
      check_latency("grant_toggle_word", oe, 0);
    end
  endtask

  task automatic test_rollback();
    int          oe;
    logic [31:0] a_exp;
    for (int c = 0; c <= 10; c++) begin
      ifc.if_addr_in = (c < 10) ? 32'h800 : 32'h0;
      ifc.mem_grant  = 1'b1;
      rdy_in         = 1'b1;
      roll_back      = (c == 9);
      a_exp          = (c >= 1 && c <= 9) ? 32'h800 + 32'(c - 1) : 32'h0;
      @(negedge clk);
      n_cmp++;
      if (ifc.mem_req !== (c >= 1 && c <= 9)) begin
        n_err++;
        $display("FAIL rollback_req cyc=%0d got=%b want=%b", c, ifc.mem_req, (c >= 1 && c <= 9));
      end
      n_cmp++;
      if (ifc.mem_a !== a_exp) begin
        n_err++;
        $display("FAIL rollback_mem_a cyc=%0d got=%h want=%h", c, ifc.mem_a, a_exp);
      end
      n_cmp++;
      if (ifc.instr_out_en !== (c == 10)) begin
        n_err++;
        $display("FAIL rollback_en cyc=%0d got=%b want=%b", c, ifc.instr_out_en, (c == 10));
      end
      if (c == 10) begin
        n_cmp++;
        if (ifc.instr_out !== 32'h03020100) begin
          n_err++;
          $display("FAIL rollback_old_line got=%h want=03020100", ifc.instr_out);
        end
      end
      next_cycle();
    end
    roll_back = 1'b0;
    fetch(32'h800, 0, 0, oe);
    check_latency("rollback_restart", oe, 18);
  endtask

  task automatic test_drain_rollback();
    int oe;
    for (int c = 0; c <= 17; c++) begin
      ifc.if_addr_in = 32'h090;
      ifc.mem_grant  = 1'b1;
      rdy_in         = 1'b1;
      roll_back      = (c == 17);
      @(negedge clk);
      n_cmp++;
      if (ifc.mem_req !== (c >= 1 && c <= 16)) begin
        n_err++;
        $display("FAIL drain_rb_req cyc=%0d got=%b want=%b", c, ifc.mem_req, (c >= 1 && c <= 16));
      end
      next_cycle();
    end
    roll_back = 1'b0;
    fetch(32'h090, 0, 0, oe);
    check_latency("drain_rb_not_written", oe, 18);
  endtask

  task automatic test_rdy_low();
    int oe;
    fetch(32'h3B0, 0, 1, oe);
    check_latency("rdy_low", oe, 21);
    for (int w = 0; w < 4; w++) begin
      fetch(32'h3B0 + 32'(w * 4), 0, 0, oe);
      check_latency("rdy_low_word", oe, 0);
    end
  endtask

  task automatic test_random();
    int          oe;
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      a = (32'($urandom_range(3)) << 10) | (32'($urandom_range(7)) << 4) | (32'($urandom_range(3)) << 2);
      fetch(a, 2, 2, oe);
    end
  endtask

  task automatic test_after_reset();
    int oe;
    test_reset();
    fetch(32'h8, 0, 0, oe);
    check_latency("after_reset_miss", oe, 18);
  endtask

  initial begin
    ifc.if_addr_in = 32'h0;
    ifc.mem_grant  = 1'b0;
    rdy_in         = 1'b0;
    roll_back      = 1'b0;
    rst_in         = 1'b1;
    test_reset();
    test_first_fill();
    test_hit_same_line();
    test_conflict();
    test_grant_toggle();
    test_rollback();
    test_drain_rollback();
    test_rdy_low();
    test_random();
    test_after_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
